// File: rtl/pipe_mips32_hz.sv
// pipe_mips32_hz: single-clock 5-stage MIPS32 pipeline (IF/ID/EX/MEM/WB) with interlocks, branch flush and halt drain.
// Configuration macro PIPE_FWD_EN: defined = EX operand forwarding; undefined = RAW hazards stall in ID until write-through.
module pipe_mips32_hz #(
    parameter int XLEN      = 32,
    parameter int MEM_DEPTH = 1024,
    parameter int MEM_AW    = 10
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              prog_we,
    input  logic [MEM_AW-1:0] prog_addr,
    input  logic [XLEN-1:0]   prog_wdata,
    input  logic [4:0]        dbg_raddr,
    output logic [XLEN-1:0]   dbg_rdata,
    output logic [MEM_AW-1:0] pc_out,
    output logic              halted,
    output logic [31:0]       retired
);
    typedef enum logic [2:0] {T_NOP, T_RR, T_RM, T_LOAD, T_STORE, T_BRANCH, T_HALT} itype_e;

    localparam logic [5:0] OP_ADD  = 6'b000000, OP_SUB  = 6'b000001, OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b000011, OP_SLT  = 6'b000100, OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW   = 6'b001000, OP_SW   = 6'b001001, OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI = 6'b001011, OP_SLTI = 6'b001100, OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ = 6'b001110;

    function automatic itype_e decode_type(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: decode_type = T_RR;
            OP_ADDI, OP_SUBI, OP_SLTI:                     decode_type = T_RM;
            OP_LW:                                         decode_type = T_LOAD;
            OP_SW:                                         decode_type = T_STORE;
            OP_BNEQZ, OP_BEQZ:                             decode_type = T_BRANCH;
            default:                                       decode_type = T_HALT;
        endcase
    endfunction

    function automatic logic writes_reg(input itype_e t);
        writes_reg = (t == T_RR) || (t == T_RM) || (t == T_LOAD);
    endfunction

    logic [XLEN-1:0]   mem_r [MEM_DEPTH];
    logic [XLEN-1:0]   regs_r [32];
    logic [MEM_AW-1:0] pc_r;
    logic              fetch_stop_r, halted_r;
    logic [31:0]       retired_r;

    logic [31:0]       if_id_ir_r;
    logic [MEM_AW-1:0] if_id_npc_r;
    logic              if_id_valid_r;

    itype_e            id_ex_type_r;
    logic [5:0]        id_ex_op_r;
    logic [4:0]        id_ex_dest_r;
    logic [XLEN-1:0]   id_ex_a_r, id_ex_b_r, id_ex_imm_r;
    logic [MEM_AW-1:0] id_ex_npc_r;
`ifdef PIPE_FWD_EN
    logic [4:0]        id_ex_rs_r, id_ex_rt_r;
`endif

    itype_e            ex_mem_type_r;
    logic [XLEN-1:0]   ex_mem_alu_r, ex_mem_b_r;
    logic [4:0]        ex_mem_dest_r;

    itype_e            mem_wb_type_r;
    logic [XLEN-1:0]   mem_wb_alu_r, mem_wb_lmd_r;
    logic [4:0]        mem_wb_dest_r;

    logic [31:0]       fetch_ir_s;
    logic [5:0]        id_op_s;
    logic [4:0]        id_rs_s, id_rt_s, id_rd_s, id_dest_s;
    itype_e            id_type_s;
    logic              id_reads_rs_s, id_reads_rt_s;
    logic [XLEN-1:0]   id_imm_s, id_a_s, id_b_s;
    logic              wb_we_s, ex_hit_s, stall_s, taken_s;
    logic [XLEN-1:0]   wb_val_s, ex_a_s, ex_b_s, ex_alu_s;
    logic [MEM_AW-1:0] ex_target_s;

    assign fetch_ir_s    = 32'(mem_r[pc_r]);
    assign id_op_s       = if_id_ir_r[31:26];
    assign id_rs_s       = if_id_ir_r[25:21];
    assign id_rt_s       = if_id_ir_r[20:16];
    assign id_rd_s       = if_id_ir_r[15:11];
    assign id_imm_s      = XLEN'($signed(if_id_ir_r[15:0]));
    assign id_type_s     = if_id_valid_r ? decode_type(id_op_s) : T_NOP;
    assign id_dest_s     = (id_type_s == T_RR) ? id_rd_s : id_rt_s;
    assign id_reads_rs_s = (id_type_s != T_NOP) && (id_type_s != T_HALT);
    assign id_reads_rt_s = (id_type_s == T_RR) || (id_type_s == T_STORE);

    // Write-through: a register being written back this cycle is read as its new value
    assign wb_we_s  = writes_reg(mem_wb_type_r) && (mem_wb_dest_r != 5'd0);
    assign wb_val_s = (mem_wb_type_r == T_LOAD) ? mem_wb_lmd_r : mem_wb_alu_r;
    assign id_a_s   = (id_rs_s == 5'd0) ? {XLEN{1'b0}} :
                      (wb_we_s && mem_wb_dest_r == id_rs_s) ? wb_val_s : regs_r[id_rs_s];
    assign id_b_s   = (id_rt_s == 5'd0) ? {XLEN{1'b0}} :
                      (wb_we_s && mem_wb_dest_r == id_rt_s) ? wb_val_s : regs_r[id_rt_s];

    assign ex_hit_s = writes_reg(id_ex_type_r) && (id_ex_dest_r != 5'd0) &&
                      ((id_reads_rs_s && id_rs_s == id_ex_dest_r) || (id_reads_rt_s && id_rt_s == id_ex_dest_r));

`ifdef PIPE_FWD_EN
    logic ex_mem_fwd_s;
    assign stall_s      = (id_ex_type_r == T_LOAD) && ex_hit_s;
    assign ex_mem_fwd_s = ((ex_mem_type_r == T_RR) || (ex_mem_type_r == T_RM)) && (ex_mem_dest_r != 5'd0);
    // Youngest producer wins: EX/MEM ALU result, then MEM/WB result, then the latched operand
    assign ex_a_s = (id_ex_rs_r == 5'd0) ? id_ex_a_r :
                    (ex_mem_fwd_s && ex_mem_dest_r == id_ex_rs_r) ? ex_mem_alu_r :
                    (wb_we_s && mem_wb_dest_r == id_ex_rs_r) ? wb_val_s : id_ex_a_r;
    assign ex_b_s = (id_ex_rt_r == 5'd0) ? id_ex_b_r :
                    (ex_mem_fwd_s && ex_mem_dest_r == id_ex_rt_r) ? ex_mem_alu_r :
                    (wb_we_s && mem_wb_dest_r == id_ex_rt_r) ? wb_val_s : id_ex_b_r;
`else
    logic mem_hit_s;
    assign mem_hit_s = writes_reg(ex_mem_type_r) && (ex_mem_dest_r != 5'd0) &&
                       ((id_reads_rs_s && id_rs_s == ex_mem_dest_r) || (id_reads_rt_s && id_rt_s == ex_mem_dest_r));
    assign stall_s   = ex_hit_s || mem_hit_s;
    assign ex_a_s    = id_ex_a_r;
    assign ex_b_s    = id_ex_b_r;
`endif

    assign ex_target_s = id_ex_npc_r + id_ex_imm_r[MEM_AW-1:0];
    assign taken_s     = (id_ex_type_r == T_BRANCH) &&
                         (((id_ex_op_r == OP_BEQZ) && (ex_a_s == {XLEN{1'b0}})) ||
                          ((id_ex_op_r == OP_BNEQZ) && (ex_a_s != {XLEN{1'b0}})));

    // EX ALU; SLT/SLTI compare unsigned
    always_comb begin
        ex_alu_s = {XLEN{1'b0}};
        case (id_ex_op_r)
            OP_ADD:       ex_alu_s = ex_a_s + ex_b_s;
            OP_SUB:       ex_alu_s = ex_a_s - ex_b_s;
            OP_AND:       ex_alu_s = ex_a_s & ex_b_s;
            OP_OR:        ex_alu_s = ex_a_s | ex_b_s;
            OP_SLT:       ex_alu_s = (ex_a_s < ex_b_s) ? XLEN'(1'b1) : {XLEN{1'b0}};
            OP_MUL:       ex_alu_s = ex_a_s * ex_b_s;
            OP_ADDI:      ex_alu_s = ex_a_s + id_ex_imm_r;
            OP_SUBI:      ex_alu_s = ex_a_s - id_ex_imm_r;
            OP_SLTI:      ex_alu_s = (ex_a_s < id_ex_imm_r) ? XLEN'(1'b1) : {XLEN{1'b0}};
            OP_LW, OP_SW: ex_alu_s = ex_a_s + id_ex_imm_r;
            default:      ex_alu_s = {XLEN{1'b0}};
        endcase
    end

    // Unified memory: the loader port wins over a store in MEM
    always_ff @(posedge clk1) begin
        if (prog_we) begin
            mem_r[prog_addr] <= prog_wdata;
        end else if ((ex_mem_type_r == T_STORE) && !halted_r) begin
            mem_r[ex_mem_alu_r[MEM_AW-1:0]] <= ex_mem_b_r;
        end
    end

    // PC and IF/ID: branch redirect, stall hold, or fetch stop once HLT has passed ID
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            pc_r          <= {MEM_AW{1'b0}};
            fetch_stop_r  <= 1'b0;
            if_id_ir_r    <= 32'd0;
            if_id_npc_r   <= {MEM_AW{1'b0}};
            if_id_valid_r <= 1'b0;
        end else if (!halted_r) begin
            if (taken_s) begin
                pc_r          <= ex_target_s;
                if_id_valid_r <= 1'b0;
            end else if (stall_s) begin
                if_id_valid_r <= if_id_valid_r;
            end else if (fetch_stop_r || (id_type_s == T_HALT)) begin
                fetch_stop_r  <= 1'b1;
                if_id_valid_r <= 1'b0;
            end else begin
                pc_r          <= pc_r + MEM_AW'(1);
                if_id_ir_r    <= fetch_ir_s;
                if_id_npc_r   <= pc_r + MEM_AW'(1);
                if_id_valid_r <= 1'b1;
            end
        end
    end

    // ID/EX latch: bubble on flush or interlock
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            id_ex_type_r <= T_NOP;
            id_ex_op_r   <= 6'd0;
            id_ex_dest_r <= 5'd0;
            id_ex_a_r    <= {XLEN{1'b0}};
            id_ex_b_r    <= {XLEN{1'b0}};
            id_ex_imm_r  <= {XLEN{1'b0}};
            id_ex_npc_r  <= {MEM_AW{1'b0}};
`ifdef PIPE_FWD_EN
            id_ex_rs_r   <= 5'd0;
            id_ex_rt_r   <= 5'd0;
`endif
        end else if (!halted_r) begin
            id_ex_type_r <= (taken_s || stall_s) ? T_NOP : id_type_s;
            id_ex_op_r   <= id_op_s;
            id_ex_dest_r <= id_dest_s;
            id_ex_a_r    <= id_a_s;
            id_ex_b_r    <= id_b_s;
            id_ex_imm_r  <= id_imm_s;
            id_ex_npc_r  <= if_id_npc_r;
`ifdef PIPE_FWD_EN
            id_ex_rs_r   <= id_rs_s;
            id_ex_rt_r   <= id_rt_s;
`endif
        end
    end

    // EX/MEM and MEM/WB latches
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            ex_mem_type_r <= T_NOP;
            ex_mem_alu_r  <= {XLEN{1'b0}};
            ex_mem_b_r    <= {XLEN{1'b0}};
            ex_mem_dest_r <= 5'd0;
            mem_wb_type_r <= T_NOP;
            mem_wb_alu_r  <= {XLEN{1'b0}};
            mem_wb_lmd_r  <= {XLEN{1'b0}};
            mem_wb_dest_r <= 5'd0;
        end else if (!halted_r) begin
            ex_mem_type_r <= id_ex_type_r;
            ex_mem_alu_r  <= ex_alu_s;
            ex_mem_b_r    <= ex_b_s;
            ex_mem_dest_r <= id_ex_dest_r;
            mem_wb_type_r <= ex_mem_type_r;
            mem_wb_alu_r  <= ex_mem_alu_r;
            mem_wb_lmd_r  <= mem_r[ex_mem_alu_r[MEM_AW-1:0]];
            mem_wb_dest_r <= ex_mem_dest_r;
        end
    end

    // Register file write-back and retirement status
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs_r[i] <= {XLEN{1'b0}};
            halted_r  <= 1'b0;
            retired_r <= 32'd0;
        end else if (!halted_r) begin
            if (wb_we_s) regs_r[mem_wb_dest_r] <= wb_val_s;
            if (mem_wb_type_r != T_NOP) retired_r <= retired_r + 32'd1;
            if (mem_wb_type_r == T_HALT) halted_r <= 1'b1;
        end
    end

    assign dbg_rdata = (dbg_raddr == 5'd0) ? {XLEN{1'b0}} : regs_r[dbg_raddr];
    assign pc_out    = pc_r;
    assign halted    = halted_r;
    assign retired   = retired_r;
endmodule

// File: tb/tb_pipe_mips32_hz.sv
// Self-checking bench for pipe_mips32_hz: directed programs plus random programs checked against an
// instruction-at-a-time reference interpreter.
module tb_pipe_mips32_hz;
    localparam int XLEN  = 32;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int PLEN  = 24;

    localparam logic [5:0] ADD = 6'd0, SUB = 6'd1, MUL = 6'd5, LW = 6'd8, SW = 6'd9;
    localparam logic [5:0] ADDI = 6'd10, SUBI = 6'd11, BNEQZ = 6'd13, BEQZ = 6'd14;

    logic            clk1 = 1'b0, rst = 1'b0, prog_we = 1'b0;
    logic [AW-1:0]   prog_addr = '0;
    logic [XLEN-1:0] prog_wdata = '0;
    logic [4:0]      dbg_raddr = '0;
    logic [XLEN-1:0] dbg_rdata;
    logic [AW-1:0]   pc_out;
    logic            halted;
    logic [31:0]     retired;

    int n_checks = 0, n_errors = 0;
    logic [XLEN-1:0] m_mem [DEPTH];
    logic [XLEN-1:0] m_regs [32];
    int              m_retired;
    logic [31:0]     prog [64];
    int              cyc;

    pipe_mips32_hz #(.XLEN(XLEN), .MEM_DEPTH(DEPTH), .MEM_AW(AW)) dut (
        .clk1(clk1), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata), .pc_out(pc_out), .halted(halted), .retired(retired)
    );

    always #5 clk1 = ~clk1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] op, input int rd, input int rs, input int rt);
        return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rt, input int rs, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic poke(input int addr, input logic [XLEN-1:0] val);
        @(negedge clk1);
        prog_we = 1'b1; prog_addr = AW'(addr); prog_wdata = val;
        @(negedge clk1);
        prog_we = 1'b0;
        m_mem[addr] = val;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 64; i++) prog[i] = 32'hFC00_0000;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 64; i++) poke(i, prog[i]);
    endtask

    // Sequential ISA interpreter: the architectural result the pipeline must match
    task automatic run_model();
        int pc, rs, rt, rd;
        logic [31:0] ir;
        logic [5:0] op;
        logic [XLEN-1:0] a, b, imm;
        bit done;
        for (int r = 0; r < 32; r++) m_regs[r] = '0;
        m_retired = 0; pc = 0; done = 0;
        for (int step = 0; step < 10000 && !done; step++) begin
            ir = m_mem[pc]; op = ir[31:26];
            rs = int'(ir[25:21]); rt = int'(ir[20:16]); rd = int'(ir[15:11]);
            a = m_regs[rs]; b = m_regs[rt]; imm = {{16{ir[15]}}, ir[15:0]};
            m_retired++;
            pc = (pc + 1) % DEPTH;
            case (op)
                6'd0:  m_regs[rd] = a + b;
                6'd1:  m_regs[rd] = a - b;
                6'd2:  m_regs[rd] = a & b;
                6'd3:  m_regs[rd] = a | b;
                6'd4:  m_regs[rd] = (a < b) ? 1 : 0;
                6'd5:  m_regs[rd] = a * b;
                6'd8:  m_regs[rt] = m_mem[int'((a + imm) & 32'(DEPTH - 1))];
                6'd9:  m_mem[int'((a + imm) & 32'(DEPTH - 1))] = b;
                6'd10: m_regs[rt] = a + imm;
                6'd11: m_regs[rt] = a - imm;
                6'd12: m_regs[rt] = (a < imm) ? 1 : 0;
                6'd13: if (a != 0) pc = int'((32'(pc) + imm) & 32'(DEPTH - 1));
                6'd14: if (a == 0) pc = int'((32'(pc) + imm) & 32'(DEPTH - 1));
                default: done = 1;
            endcase
            m_regs[0] = '0;
        end
    endtask

    task automatic start_test();
        @(negedge clk1);
        rst = 1'b1;
        #1;
        check_eq("reset_pc", pc_out, 0);
        check_eq("reset_halted", halted, 0);
        check_eq("reset_retired", retired, 0);
    endtask

    // Release reset and clock until halted; optional loader write to paddr lands on edge pulse_cyc
    task automatic run_dut(input int budget, input int pulse_cyc, input int paddr, input logic [XLEN-1:0] pval);
        @(negedge clk1);
        rst = 1'b0;
        cyc = 0;
        while (cyc < budget && !halted) begin
            if (cyc + 1 == pulse_cyc) begin
                prog_we = 1'b1; prog_addr = AW'(paddr); prog_wdata = pval;
            end
            @(posedge clk1);
            cyc++;
            #1;
            prog_we = 1'b0;
        end
        check_eq("halt_reached", halted, 1);
    endtask

    task automatic reg_val(input int r, output logic [XLEN-1:0] v);
        dbg_raddr = 5'(r);
        #1;
        v = dbg_rdata;
    endtask

    task automatic compare_state(input string tag);
        logic [XLEN-1:0] v;
        for (int r = 0; r < 32; r++) begin
            reg_val(r, v);
            check_eq($sformatf("%s_R%0d", tag, r), v, m_regs[r]);
        end
        check_eq({tag, "_retired"}, retired, m_retired);
    endtask

    initial begin
        logic [XLEN-1:0] v;
        int k, rd, rs, rt;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [XLEN-1:0] v;
        int k, rd, rs, rt;

        // Back-to-back RAW
        start_test();
        clear_prog();
        prog[0] = enc_i(ADDI, 1, 0, 10); prog[1] = enc_i(ADDI, 2, 0, 20);
        prog[2] = enc_r(ADD, 3, 1, 2);   prog[3] = enc_r(SUB, 4, 3, 1);
        load_prog(); run_model(); run_dut(500, 0, 0, '0);
        reg_val(3, v); check_eq("raw_R3", v, 30);
        reg_val(4, v); check_eq("raw_R4", v, 20);
        check_eq("raw_retired", retired, 5);
`ifdef PIPE_FWD_EN
        check_eq("raw_halt_cycle", cyc, 9);
`endif
        compare_state("raw");

        // Load-use interlock
        start_test();
        clear_prog();
        poke(100, 55);
        prog[0] = enc_i(ADDI, 1, 0, 100); prog[1] = enc_i(LW, 2, 1, 0); prog[2] = enc_r(ADD, 3, 2, 2);
        load_prog(); run_model(); run_dut(500, 0, 0, '0);
        reg_val(3, v); check_eq("lu_R3", v, 110);
        check_eq("lu_retired", retired, 4);
`ifdef PIPE_FWD_EN
        check_eq("lu_halt_cycle", cyc, 9);
`endif
        compare_state("lu");

        // Loop with taken branches; shadow instructions must never write back
        start_test();
        clear_prog();
        prog[0] = enc_i(ADDI, 1, 0, 5); prog[1] = enc_i(ADDI, 2, 0, 1);
        prog[2] = enc_r(MUL, 2, 2, 1);  prog[3] = enc_i(SUBI, 1, 1, 1);
        prog[4] = enc_i(BNEQZ, 0, 1, -3);
        prog[6] = enc_i(ADDI, 7, 0, 99); prog[7] = enc_i(ADDI, 8, 0, 77);
        load_prog(); run_model(); run_dut(1000, 0, 0, '0);
        reg_val(2, v); check_eq("loop_R2", v, 120);
        reg_val(7, v); check_eq("loop_R7", v, 0);
        check_eq("loop_retired", retired, 18);
        compare_state("loop");

        // Reset mid-run, then rerun
        start_test();
        @(negedge clk1); rst = 1'b0;
        repeat (12) @(posedge clk1);
        #3; rst = 1'b1; #1;
        check_eq("midrst_pc", pc_out, 0);
        check_eq("midrst_halted", halted, 0);
        check_eq("midrst_retired", retired, 0);
        reg_val(2, v); check_eq("midrst_R2", v, 0);
        run_dut(1000, 0, 0, '0);
        reg_val(2, v); check_eq("rerun_R2", v, 120);
        check_eq("rerun_retired", retired, 18);

        // Store then load
        start_test();
        clear_prog();
        prog[0] = enc_i(ADDI, 1, 0, 7); prog[1] = enc_i(SW, 1, 0, 200); prog[2] = enc_i(LW, 2, 0, 200);
        load_prog(); run_model(); run_dut(500, 0, 0, '0);
        reg_val(2, v); check_eq("st_R2", v, 7);
        compare_state("st");

        // Loader write in the store's MEM cycle wins
        start_test();
`ifdef PIPE_FWD_EN
        run_dut(500, 5, 200, 32'hABCD_1234);
`else
        run_dut(500, 7, 200, 32'hABCD_1234);
`endif
        m_mem[200] = 32'hABCD_1234;
        reg_val(2, v); check_eq("prog_wins_R2", v, 32'hABCD_1234);

        // R0 immutability and unknown opcode as halt
        start_test();
        clear_prog();
        prog[0] = enc_i(ADDI, 1, 0, 9); prog[1] = enc_i(ADDI, 0, 0, 5);
        prog[2] = enc_r(ADD, 1, 0, 0);  prog[3] = 32'h5400_0000;
        prog[4] = enc_i(ADDI, 5, 0, 3);
        load_prog(); run_model(); run_dut(500, 0, 0, '0);
        reg_val(0, v); check_eq("r0_R0", v, 0);
        reg_val(1, v); check_eq("r0_R1", v, 0);
        reg_val(5, v); check_eq("r0_R5", v, 0);
        check_eq("unk_retired", retired, 4);
        compare_state("unk");

        // Random programs against the interpreter
        for (int t = 0; t < 12; t++) begin
            start_test();
            clear_prog();
            for (int d = 300; d < 308; d++) poke(d, $urandom);
            for (int i = 0; i < PLEN; i++) begin
                k = $urandom_range(0, 9);
                rd = $urandom_range(0, 7); rs = $urandom_range(0, 7); rt = $urandom_range(0, 7);
                case (k)
                    0, 1, 2: prog[i] = enc_r(6'($urandom_range(0, 5)), rd, rs, rt);
                    3, 4:    prog[i] = enc_i(6'($urandom_range(10, 12)), rt, rs, int'($urandom_range(0, 65535)));
                    5, 6:    prog[i] = enc_i(LW, rt, 0, 300 + int'($urandom_range(0, 7)));
                    7:       prog[i] = enc_i(SW, rt, 0, 300 + int'($urandom_range(0, 7)));
                    8:       prog[i] = enc_i(($urandom_range(0, 1) == 0) ? BEQZ : BNEQZ, 0, rs, int'($urandom_range(0, 2)));
                    default: prog[i] = enc_r(ADD, rd, rt, rt);
                endcase
            end
            load_prog(); run_model(); run_dut(1000, 0, 0, '0);
            compare_state($sformatf("rnd%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/pipe_mips32_hz.md
Name: pipe_mips32_hz

Overview:
- Next-generation single-clock 5-stage pipelined MIPS32 core (IF, ID, EX, MEM, WB) replacing the two-phase-clock core.
- Adds hardware hazard handling: EX operand forwarding, load-use interlock, branch flush and a drain-to-halt sequence.
- Adds parametrised data width and memory depth, plus a program-load and debug port.
- Keeps the existing instruction encoding: ADD 000000, SUB 000001, AND 000010, OR 000011, SLT 000100, MUL 000101, LW 001000, SW 001001, ADDI 001010, SUBI 001011, SLTI 001100, BNEQZ 001101, BEQZ 001110, HLT 111111.

Parameters:
XLEN, 32, datapath and register width (>=16)
MEM_DEPTH, 1024, words in unified instruction/data memory
MEM_AW, 10, memory address width, clog2(MEM_DEPTH)

Ports:
clk1  input  1  single core clock, all state on rising edge
rst  input  1  asynchronous active-high reset
prog_we  input  1  memory write strobe from loader/testbench
prog_addr  input  MEM_AW  memory word address for prog_we
prog_wdata  input  XLEN  data written when prog_we=1
dbg_raddr  input  5  register index for debug read
dbg_rdata  output  XLEN  combinational Reg[dbg_raddr], R0 reads 0
pc_out  output  MEM_AW  current fetch PC
halted  output  1  high once HLT has retired
retired  output  32  count of instructions retired in WB

Behaviour:
- Interface: one clock (clk1); reset rst is asynchronous and active-high.
- Reset: PC=0, halted=0, retired=0, all 32 registers =0, every pipeline latch holds a bubble (type NOP, no writes). Memory is not cleared. Reset mid-program discards all in-flight instructions.
- Memory: async read, sync write. prog_we writes at any time. If prog_we and a SW target the same cycle, prog_we wins and the SW is dropped. All addresses use the low MEM_AW bits, so addresses wrap.
- Immediate: IR[15:0] sign-extended to XLEN. rs=IR[25:21], rt=IR[20:16], rd=IR[15:11].
- ALU results:
  - SLT/SLTI: unsigned compare, 1/0 zero-extended.
  - MUL: low XLEN bits of the product.
  - Add/sub: wrap modulo 2^XLEN.
- Register file: R0 write discarded, R0 read returns 0. A WB write and an ID read of the same register in one cycle return the new value (write-through).
- Latency: non-hazard throughput 1 instr/cycle. An instruction fetched at cycle n writes back at cycle n+4.
- Forwarding into EX for rs and rt:
  - Source order: EX/MEM result (ALU types only), then MEM/WB result (ALU or load data), then the ID/EX latch.
  - The youngest producer wins.
  - Never forward from R0 or from bubbles, stores, branches or HLT.
- Load-use interlock: an instruction in ID that reads rs/rt equal to the rt of an LW in EX stalls for 1 cycle. PC and IF/ID are held and a bubble is injected into EX. SW's rt source counts as a read.
- Branch: BEQZ taken if forwarded A==0; BNEQZ taken if A!=0. Target = NPC+Imm, resolved in EX. When taken: PC<=target, IF/ID and ID/EX become bubbles (2-cycle penalty). A taken branch overrides a simultaneous load-use stall.
- Halt:
  - Unknown opcode decodes as HLT.
  - HLT in ID stops fetch: PC frozen, bubbles inserted behind it. A taken branch in EX that same cycle flushes the HLT instead.
  - Older instructions complete normally.
  - When HLT reaches WB: halted<=1 and all stages freeze until rst. prog_we and dbg reads still work while halted.
- retired increments once per non-bubble instruction in WB, HLT included, and wraps at 2^32.

Optional Feature:
- Macro PIPE_FWD_EN.
- Defined: forwarding network as described.
- Undefined: no forwarding paths. An instruction in ID with a RAW dependency on any producer in EX or MEM stalls until the producer reaches WB, where the write-through read resolves it. Load-use and branch rules are unchanged. Results must be identical with or without the macro; only cycle counts differ.

Test Plan:
- Back-to-back RAW: ADDI R1,R0,10; ADDI R2,R0,20; ADD R3,R1,R2; SUB R4,R3,R1; HLT -> R3=30, R4=20, retired=5, halted at cycle 9 with PIPE_FWD_EN.
- Load-use: Mem[100]=55; ADDI R1,R0,100; LW R2,0(R1); ADD R3,R2,R2; HLT -> exactly one stall bubble, R3=110, retired=4.
- Loop: R1=5, R2=1; loop MUL R2,R2,R1; SUBI R1,R1,1; BNEQZ R1,-3; HLT -> R2=120. The two instructions after each taken branch never write back.
- Store/load: ADDI R1,R0,7; SW R1,200(R0); LW R2,200(R0); HLT -> Mem[200]=7, R2=7. prog_we to 200 in the SW's MEM cycle leaves Mem[200]=prog_wdata.
- R0 and unknown opcode: ADDI R0,R0,5; ADD R1,R0,R0; opcode 010101 -> R0 reads 0, R1=0, halted=1 after the unknown opcode retires.
- Reset mid-run: assert rst during the loop test -> outputs return to reset values immediately. After release and re-run, the result is again R2=120.
